// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types.
//   word_t      - 32-bit data word
//   regbits_t   - 5-bit register index
//   arb_state_t - register-file write arbiter state (NORMAL / FAVOR_MDU)
//   REG_ZERO    - hardwired-zero register index
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic {
    NORMAL    = 1'b0,
    FAVOR_MDU = 1'b1
  } arb_state_t;

  localparam regbits_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_arb_if.sv
// regfile_arb_if: the two register-file write request channels
// (pipeline writeback and multiply/divide unit), valid/ready each.
//   src modport : requester view (drives valid/wsel/wdat, sees ready)
//   arb modport : arbiter view (sees valid/wsel/wdat, drives ready)
interface regfile_arb_if;
  import cpu_types_pkg::*;

  logic     wb_valid;
  regbits_t wb_wsel;
  word_t    wb_wdat;
  logic     wb_ready;

  logic     mdu_valid;
  regbits_t mdu_wsel;
  word_t    mdu_wdat;
  logic     mdu_ready;

  modport src (output wb_valid, wb_wsel, wb_wdat, mdu_valid, mdu_wsel, mdu_wdat,
               input  wb_ready, mdu_ready);
  modport arb (input  wb_valid, wb_wsel, wb_wdat, mdu_valid, mdu_wsel, mdu_wdat,
               output wb_ready, mdu_ready);
endinterface

// File: rtl/regfile_arb_age.sv
// regfile_arb_age: MDU starvation guard.
// Counts consecutive cycles the MDU is valid but refused; once the count
// reaches MAX_WAIT the FSM enters FAVOR_MDU for exactly one MDU transfer.
// Ports:
//   CLK, nRST  - clock, asynchronous active-low reset
//   mdu_valid  - MDU request present
//   mdu_xfer   - MDU transfer (valid && ready) this cycle
//   force_mdu  - state is FAVOR_MDU: MDU must be granted
module regfile_arb_age
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic mdu_valid,
  input  logic mdu_xfer,
  output logic force_mdu
);

  localparam logic [WAIT_W-1:0] LP_MAX = WAIT_W'(MAX_WAIT);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic [WAIT_W-1:0] w_cnt_inc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= NORMAL;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_cnt_inc   = (r_wait_cnt == LP_MAX) ? r_wait_cnt : r_wait_cnt + WAIT_W'(1);
    case (r_state)
      NORMAL: begin
        if (!mdu_valid || mdu_xfer) begin
          w_wait_nxt = '0;
        end else begin
          w_wait_nxt = w_cnt_inc;
          if (w_cnt_inc == LP_MAX) w_state_nxt = FAVOR_MDU;
        end
      end
      FAVOR_MDU: begin
        // Leaves after one cycle either way: a valid MDU is always
        // accepted here, and a dropped MDU request abandons the favour.
        w_wait_nxt  = '0;
        w_state_nxt = NORMAL;
      end
      default: begin
        w_wait_nxt  = '0;
        w_state_nxt = NORMAL;
      end
    endcase
  end

  assign force_mdu = (r_state == FAVOR_MDU);

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between the
// pipeline writeback (WB, fixed priority) and the MDU, with a starvation
// override from regfile_arb_age. The rf_* outputs are registered so a
// negedge-write register file sees stable values all cycle.
// Ports:
//   CLK, nRST                    - clock, asynchronous active-low reset
//   wb_valid/wb_wsel/wb_wdat     - WB request;  wb_ready  accept
//   mdu_valid/mdu_wsel/mdu_wdat  - MDU request; mdu_ready accept
//   rf_WEN/rf_wsel/rf_wdat       - registered register-file write port
//   mdu_forced                   - MDU granted by the starvation override
//   stat_conflicts, stat_forced  - only with REGFILE_ARB_STATS_EN defined
module regfile_write_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic     CLK,
  input  logic     nRST,
  input  logic     wb_valid,
  input  regbits_t wb_wsel,
  input  word_t    wb_wdat,
  output logic     wb_ready,
  input  logic     mdu_valid,
  input  regbits_t mdu_wsel,
  input  word_t    mdu_wdat,
  output logic     mdu_ready,
  output logic     rf_WEN,
  output regbits_t rf_wsel,
  output word_t    rf_wdat,
  output logic     mdu_forced
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [31:0] stat_conflicts,
  output logic [31:0] stat_forced
`endif
);

  regfile_arb_if w_req ();

  assign w_req.wb_valid  = wb_valid;
  assign w_req.wb_wsel   = wb_wsel;
  assign w_req.wb_wdat   = wb_wdat;
  assign w_req.mdu_valid = mdu_valid;
  assign w_req.mdu_wsel  = mdu_wsel;
  assign w_req.mdu_wdat  = mdu_wdat;
  assign wb_ready        = w_req.wb_ready;
  assign mdu_ready       = w_req.mdu_ready;

  logic     w_force;
  logic     w_wb_xfer;
  logic     w_mdu_xfer;
  logic     w_xfer;
  regbits_t w_win_wsel;
  word_t    w_win_wdat;

  logic     r_wen;
  regbits_t r_wsel;
  word_t    r_wdat;

  regfile_arb_age #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_age (
    .CLK       (CLK),
    .nRST      (nRST),
    .mdu_valid (w_req.mdu_valid),
    .mdu_xfer  (w_mdu_xfer),
    .force_mdu (w_force)
  );

  // Grant mux. Readies are gated by the requester's own valid so they read
  // 0 whenever nothing is requesting.
  always_comb begin
    w_req.wb_ready  = 1'b0;
    w_req.mdu_ready = 1'b0;
    if (w_force) begin
      w_req.mdu_ready = w_req.mdu_valid;
    end else if (w_req.wb_valid) begin
      w_req.wb_ready  = 1'b1;
    end else begin
      w_req.mdu_ready = w_req.mdu_valid;
    end
  end

  assign w_wb_xfer  = w_req.wb_valid  && w_req.wb_ready;
  assign w_mdu_xfer = w_req.mdu_valid && w_req.mdu_ready;
  assign w_xfer     = w_wb_xfer || w_mdu_xfer;
  assign w_win_wsel = w_wb_xfer ? w_req.wb_wsel : w_req.mdu_wsel;
  assign w_win_wdat = w_wb_xfer ? w_req.wb_wdat : w_req.mdu_wdat;
  assign mdu_forced = w_force && w_req.mdu_valid;

  // Writes to register 0 are accepted upstream but never enabled here.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wen  <= 1'b0;
      r_wsel <= '0;
      r_wdat <= '0;
    end else begin
      r_wen <= w_xfer && (w_win_wsel != REG_ZERO);
      if (w_xfer) begin
        r_wsel <= w_win_wsel;
        r_wdat <= w_win_wdat;
      end
    end
  end

  assign rf_WEN  = r_wen;
  assign rf_wsel = r_wsel;
  assign rf_wdat = r_wdat;

`ifdef REGFILE_ARB_STATS_EN
  logic [31:0] r_stat_conflicts;
  logic [31:0] r_stat_forced;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stat_conflicts <= '0;
      r_stat_forced    <= '0;
    end else begin
      if (w_req.wb_valid && w_req.mdu_valid) r_stat_conflicts <= r_stat_conflicts + 32'd1;
      if (w_force && w_mdu_xfer)             r_stat_forced    <= r_stat_forced + 32'd1;
    end
  end

  assign stat_conflicts = r_stat_conflicts;
  assign stat_forced    = r_stat_forced;
`endif

endmodule
